// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and shared-memory handshake signals around the arbiter.
// The master view belongs to the arbiter; the slave view belongs to the requesters and memory.
interface mem_port_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  i_req;
   logic [ADDR_WIDTH-1:0] i_addr;
   logic                  i_ack;
   logic [DATA_WIDTH-1:0] i_rdata;

   logic                  d_req;
   logic                  d_we;
   logic [ADDR_WIDTH-1:0] d_addr;
   logic [DATA_WIDTH-1:0] d_wdata;
   logic                  d_ack;
   logic [DATA_WIDTH-1:0] d_rdata;

   logic                  stall_f;
   logic                  stall_m;

   logic                  mem_req;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic                  mem_ack;
   logic [DATA_WIDTH-1:0] mem_rdata;

   modport master (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
      output i_ack, i_rdata, d_ack, d_rdata, stall_f, stall_m,
             mem_req, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
      input  i_ack, i_rdata, d_ack, d_rdata, stall_f, stall_m,
             mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port memory between the fetch and data requesters.
// Data normally wins; fetch takes the port after STARVE_LIMIT consecutive losses.
//
// state   | meaning
// IDLE    | no transfer; the only state in which a grant is made
// SERVE_I | fetch command on the memory port, waiting for mem_ack
// SERVE_D | data command on the memory port, waiting for mem_ack
// DONE    | one-cycle ack to the owner with the captured response
module mem_port_arbiter #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 16
) (
   input  logic                clk,
   input  logic                rst,
   mem_port_arbiter_if.master  bus,
   output logic                bus_err
);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;

   state_t                state;
   state_t                state_nxt;
   logic [SW-1:0]         starve_cnt;
   logic [TW-1:0]         tmo_cnt;
   logic [ADDR_WIDTH-1:0] lat_addr;
   logic [DATA_WIDTH-1:0] lat_wdata;
   logic                  lat_we;
   logic                  owner_d;
   logic [DATA_WIDTH-1:0] resp_data;

   logic grant_d;
   logic grant_i;
   logic serving;
   logic tmo_hit;

   assign serving = (state == SERVE_I) || (state == SERVE_D);
   assign tmo_hit = serving && !bus.mem_ack && (tmo_cnt == TW'(TIMEOUT - 1));
   // Data wins a tie unless fetch has already lost STARVE_LIMIT times in a row.
   assign grant_d = bus.d_req && !(bus.i_req && (starve_cnt == SW'(STARVE_LIMIT)));
   assign grant_i = bus.i_req && !grant_d;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (grant_d)      state_nxt = SERVE_D;
            else if (grant_i) state_nxt = SERVE_I;
         end
         SERVE_I, SERVE_D: begin
            if (bus.mem_ack || tmo_hit) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
         tmo_cnt    <= '0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         lat_we     <= 1'b0;
         owner_d    <= 1'b0;
         resp_data  <= '0;
         bus_err    <= 1'b0;
      end else begin
         if (state == IDLE) begin
            if (grant_d) begin
               lat_addr  <= bus.d_addr;
               lat_wdata <= bus.d_wdata;
               lat_we    <= bus.d_we;
               owner_d   <= 1'b1;
               tmo_cnt   <= '0;
               if (bus.i_req && (starve_cnt != SW'(STARVE_LIMIT)))
                  starve_cnt <= starve_cnt + 1'b1;
            end else if (grant_i) begin
               lat_addr   <= bus.i_addr;
               lat_wdata  <= '0;
               lat_we     <= 1'b0;
               owner_d    <= 1'b0;
               tmo_cnt    <= '0;
               starve_cnt <= '0;
            end
         end else if (serving) begin
            if (bus.mem_ack) begin
               resp_data <= bus.mem_rdata;
            end else if (tmo_hit) begin
               resp_data <= '0;
               bus_err   <= 1'b1;
            end else begin
               tmo_cnt <= tmo_cnt + 1'b1;
            end
         end
      end
   end

   always_comb begin
      bus.mem_req   = serving;
      bus.mem_we    = lat_we;
      bus.mem_addr  = lat_addr;
      bus.mem_wdata = lat_wdata;
      bus.i_ack     = (state == DONE) && !owner_d;
      bus.d_ack     = (state == DONE) && owner_d;
      bus.i_rdata   = bus.i_ack ? resp_data : '0;
      bus.d_rdata   = bus.d_ack ? resp_data : '0;
      bus.stall_f   = bus.i_req && !bus.i_ack;
      bus.stall_m   = bus.d_req && !bus.d_ack;
   end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, width of all address ports.
REQ-002 Parameter DATA_WIDTH, default 32, width of all data ports.
REQ-003 Parameter STARVE_LIMIT, default 4, consecutive fetch losses before fetch gets priority.
REQ-004 Parameter TIMEOUT, default 16, SERVE cycles without mem_ack before the transfer is aborted.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 i_req  input  1  fetch requester read request; held high until i_ack.
REQ-008 i_addr  input  ADDR_WIDTH  fetch read address.
REQ-009 i_ack  output  1  one-cycle fetch completion pulse.
REQ-010 i_rdata  output  DATA_WIDTH  fetch read data, valid while i_ack high.
REQ-011 d_req  input  1  data (MEM stage) request; held high until d_ack.
REQ-012 d_we  input  1  1 = store, 0 = load.
REQ-013 d_addr  input  ADDR_WIDTH  data address.
REQ-014 d_wdata  input  DATA_WIDTH  store data.
REQ-015 d_ack  output  1  one-cycle data completion pulse.
REQ-016 d_rdata  output  DATA_WIDTH  load data, valid while d_ack high.
REQ-017 stall_f  output  1  combinational: i_req && !i_ack; freezes fetch stage.
REQ-018 stall_m  output  1  combinational: d_req && !d_ack; freezes MEM stage and upstream.
REQ-019 mem_req, mem_we, mem_addr, mem_wdata  output  1/1/ADDR_WIDTH/DATA_WIDTH  shared single-port memory command.
REQ-020 mem_ack  input  1  memory completion; mem_rdata valid same cycle.
REQ-021 mem_rdata  input  DATA_WIDTH  memory read data.
REQ-022 bus_err  output  1  sticky timeout flag.

Function
REQ-023 FSM states SHALL be IDLE, SERVE_I, SERVE_D, DONE; grants occur only in IDLE.
REQ-024 IDLE, d_req only -> SERVE_D; i_req only -> SERVE_I; both -> SERVE_D unless starve_cnt == STARVE_LIMIT, then SERVE_I; neither -> IDLE.
REQ-025 On grant, addr, wdata, we SHALL be latched into internal regs (we forced 0 for fetch); mem_* driven only from these regs.
REQ-026 mem_req SHALL be 1 exactly while in SERVE_I/SERVE_D; mem_we/addr/wdata hold latched values throughout.
REQ-027 SERVE_x with mem_ack -> DONE; mem_rdata captured into response reg; owner tag recorded.
REQ-028 DONE lasts exactly one cycle; asserts the owner's ack with response data; other ack 0; next state IDLE.
REQ-029 req inputs sampled in DONE SHALL be ignored; requester drops or re-presents req in the cycle after its ack.
REQ-030 Minimum latency: req at cycle t, mem_req t+1, mem_ack t+1, ack t+2, next grant evaluated t+3.
REQ-031 starve_cnt (saturating at STARVE_LIMIT) SHALL increment on each D grant while i_req high, clear on each I grant.
REQ-032 Timeout counter clears on grant, increments each SERVE cycle without mem_ack; on reaching TIMEOUT-1 without ack: mem_req drops, -> DONE, ack pulses with rdata 0, bus_err set.
REQ-033 mem_ack outside SERVE states SHALL be ignored.
REQ-034 i_rdata/d_rdata SHALL read 0 whenever corresponding ack is 0.

Reset
REQ-035 rst high at an edge SHALL force IDLE, starve_cnt 0, timeout 0, latched regs 0, bus_err 0; mem_req, i_ack, d_ack 0 from that edge.
REQ-036 rst mid-transfer SHALL abandon the transfer with no ack; stall outputs then follow req inputs.
REQ-037 bus_err SHALL clear only by rst.

Verification
REQ-038 i_req, i_addr 0x10, memory acks next cycle with 0xDEADBEEF -> mem_req 1 cycle, i_ack pulse cycle t+2, i_rdata 0xDEADBEEF, stall_f high t..t+1.
REQ-039 i_req and d_req (store 0x20, 0x55) same cycle -> store served first with mem_we 1; fetch granted after d_ack; d_ack precedes i_ack.
REQ-040 d_req held continuously re-asserted with i_req high, STARVE_LIMIT 4 -> 4 D grants, then I grant, starve_cnt back to 0.
REQ-041 mem_ack never arrives, TIMEOUT 16 -> mem_req high 16 cycles, then ack pulse with rdata 0, bus_err 1 persisting until rst.
REQ-042 rst asserted in SERVE_D -> next cycle IDLE, mem_req 0, no d_ack, bus_err 0; re-issued d_req completes normally.
